msp430_inst_encoder: RTL and testbench
======================================

MSP430_INST_ENCODER -- requirements
Module: msp430_inst_encoder

Interface
REQ-001 SHALL have no parameters; all widths are fixed by the MSP430 instruction format.
REQ-002 SHALL have ports: mclk in 1 (single clock, all logic on rising edge); puc_rst_n in 1 (reset, synchronous, active-low).
REQ-003 SHALL have ports: req_valid in 1 (instruction request); req_ready out 1 (request accepted when both high at a mclk edge).
REQ-004 SHALL have ports: req_fmt in 2 (0=SIG-OP, 1=JUMP, 2=TWO-OP, 3=illegal); req_op in 4 (TWO-OP opcode[15:12] 4..F; SIG-OP index 0..6 = RRC, SWPB, RRA, SXT, PUSH, CALL, RETI; JUMP condition 0..7); req_bw in 1 (byte mode).
REQ-005 SHALL have ports: req_src in 4; req_as in 2; req_dst in 4; req_ad in 1; req_joff in 10 (jump offset, in words); req_ext_src in 16; req_ext_dst in 16.
REQ-006 SHALL have ports: word_valid out 1; word_ready in 1; word_data out 16; word_last out 1 (final word of the instruction); word_idx out 2 (0=opcode, 1=src ext, 2=dst ext).
REQ-007 SHALL have ports: err out 1 (one-cycle pulse on an illegal request); busy out 1; inst_count out 32 (number of instructions fully emitted).

Function
REQ-008 State machine SHALL have states IDLE, OPC, EXT_SRC, EXT_DST; req_ready=1 only in IDLE with puc_rst_n=1; busy=1 whenever the state is not IDLE.
REQ-009 On request acceptance, all req_* fields SHALL be latched; later changes to req_* SHALL have no effect until the next acceptance.
REQ-010 TWO-OP opcode word SHALL be {req_op, src, ad, bw, as, dst}.
REQ-011 SIG-OP opcode word SHALL be {6'b000100, op[2:0], bw', as, src}; bw'=0 for SWPB/SXT/CALL; RETI SHALL be exactly 16'h1300.
REQ-012 JUMP opcode word SHALL be {3'b001, op[2:0], joff}.
REQ-013 Source extension word SHALL be required (SIG-OP except RETI, and TWO-OP) when: as=01 and src!=3; or as=11 and src=0.
REQ-014 Destination extension word SHALL be required when the format is TWO-OP and ad=1.
REQ-015 Emission order SHALL be opcode, then src ext, then dst ext; words that are not required SHALL be skipped.
REQ-016 word_valid SHALL rise on the cycle after acceptance (latency 1); word_data, word_idx and word_last SHALL be held stable while word_valid=1 and word_ready=0.
REQ-017 A word SHALL be consumed at a mclk edge with word_valid and word_ready both high; the FSM SHALL then advance to the next required word, or to IDLE after the last word, with no bubble cycles between words.
REQ-018 word_last SHALL be 1 only on the final word of each instruction.
REQ-019 inst_count SHALL increment by 1 on consumption of a word with word_last=1, and SHALL wrap from FFFF_FFFF to 0.
REQ-020 An illegal request (fmt=3; TWO-OP with op<4; SIG-OP with op>6) SHALL be accepted, SHALL pulse err for the cycle after acceptance, SHALL emit no words, SHALL leave inst_count unchanged and SHALL stay in IDLE.
REQ-021 In IDLE, word_valid SHALL be 0, and word_data SHALL be 0.
REQ-022 A request that arrives while the FSM is not in IDLE SHALL NOT be accepted; req_valid SHALL be allowed to remain high until req_ready=1.

Reset
REQ-023 While puc_rst_n=0 at a mclk edge: state=IDLE; word_valid=0; word_data=0; word_last=0; word_idx=0; err=0; inst_count=0; latched fields=0.
REQ-024 While puc_rst_n=0, req_ready SHALL be 0 and no request SHALL be accepted.
REQ-025 Reset during emission SHALL abort the current instruction with no further words and no count increment; normal operation SHALL resume on the first edge with puc_rst_n=1.

Verification
REQ-026 MOV.W R5,R6 (fmt=2, op=4, src=5, as=0, ad=0, dst=6), word_ready=1 -> single word 0x4506, idx=0, last=1; inst_count=1.
REQ-027 ADD #0x1234,&0x0200 (op=5, src=0, as=3, ad=1, dst=2, ext_src=0x1234, ext_dst=0x0200) -> 0x50B2, 0x1234, 0x0200 on consecutive cycles; idx 0, 1, 2; last only on 0x0200.
REQ-028 JMP -1 (fmt=1, op=7, joff=0x3FF) -> 0x3FFF, last=1; CALL #N (fmt=0, op=5, src=0, as=3, bw=1, ext_src=0xF000) -> 0x12B0 with bw forced to 0, then 0xF000.
REQ-029 Backpressure: word_ready=0 for 3 cycles on the 0x50B2 word -> word_data held at 0x50B2 and word_valid held at 1; after word_ready=1 the sequence continues unchanged.
REQ-030 Illegal request fmt=3 -> err=1 for exactly one cycle, word_valid stays 0, inst_count unchanged, req_ready=1 on the next cycle.
REQ-031 puc_rst_n=0 for one edge after 0x50B2 is consumed -> no 0x1234 or 0x0200 words; inst_count=0; the next MOV request produces 0x4506 normally.

Source files
------------

// File: rtl/msp430_inst_encoder.sv
// MSP430 instruction encoder: accepts one decoded instruction request and
// streams its opcode word plus any required extension words.
module msp430_inst_encoder (
  input  logic        mclk,
  input  logic        puc_rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [1:0]  req_fmt,
  input  logic [3:0]  req_op,
  input  logic        req_bw,
  input  logic [3:0]  req_src,
  input  logic [1:0]  req_as,
  input  logic [3:0]  req_dst,
  input  logic        req_ad,
  input  logic [9:0]  req_joff,
  input  logic [15:0] req_ext_src,
  input  logic [15:0] req_ext_dst,
  output logic        word_valid,
  input  logic        word_ready,
  output logic [15:0] word_data,
  output logic        word_last,
  output logic [1:0]  word_idx,
  output logic        err,
  output logic        busy,
  output logic [31:0] inst_count
);

  localparam logic [1:0] FmtSig  = 2'd0;
  localparam logic [1:0] FmtJump = 2'd1;
  localparam logic [1:0] FmtTwo  = 2'd2;

  typedef enum logic [1:0] {StIdle, StOpc, StExtSrc, StExtDst} state_e;

  state_e      r_state, w_state_nxt;
  logic [1:0]  r_fmt;
  logic [3:0]  r_op;
  logic        r_bw;
  logic [3:0]  r_src;
  logic [1:0]  r_as;
  logic [3:0]  r_dst;
  logic        r_ad;
  logic [9:0]  r_joff;
  logic [15:0] r_ext_src;
  logic [15:0] r_ext_dst;
  logic        r_err;
  logic [31:0] r_inst_count;

  logic        w_accept;
  logic        w_req_illegal;
  logic        w_consume;
  logic        w_need_src;
  logic        w_need_dst;
  logic        w_sig_bw;
  logic [15:0] w_opcode;

  assign req_ready  = puc_rst_n && (r_state == StIdle);
  assign busy       = (r_state != StIdle);
  assign w_accept   = req_valid && req_ready;
  assign word_valid = (r_state != StIdle);
  assign w_consume  = word_valid && word_ready;
  assign err        = r_err;
  assign inst_count = r_inst_count;

  // Illegal requests are judged on the live request fields at acceptance.
  assign w_req_illegal = (req_fmt == 2'd3)
                      || ((req_fmt == FmtTwo) && (req_op < 4'd4))
                      || ((req_fmt == FmtSig) && (req_op > 4'd6));

  // Extension-word requirements derived from the latched instruction.
  always_comb begin
    w_need_src = 1'b0;
    if ((r_fmt == FmtTwo) || ((r_fmt == FmtSig) && (r_op != 4'd6))) begin
      w_need_src = ((r_as == 2'b01) && (r_src != 4'd3))
                || ((r_as == 2'b11) && (r_src == 4'd0));
    end
    w_need_dst = (r_fmt == FmtTwo) && r_ad;
  end

  // SWPB, SXT and CALL have no byte form, so their B/W bit is always 0.
  assign w_sig_bw = r_bw && !((r_op == 4'd1) || (r_op == 4'd3) || (r_op == 4'd5));

  // Opcode word assembly per instruction format.
  always_comb begin
    w_opcode = 16'h0000;
    case (r_fmt)
      FmtTwo:  w_opcode = {r_op, r_src, r_ad, r_bw, r_as, r_dst};
      FmtJump: w_opcode = {3'b001, r_op[2:0], r_joff};
      FmtSig: begin
        if (r_op == 4'd6) w_opcode = 16'h1300;
        else              w_opcode = {6'b000100, r_op[2:0], w_sig_bw, r_as, r_src};
      end
      default: w_opcode = 16'h0000;
    endcase
  end

  // Next-state selection and word outputs; IDLE drives all-zero outputs.
  always_comb begin
    w_state_nxt = r_state;
    word_data   = 16'h0000;
    word_idx    = 2'd0;
    word_last   = 1'b0;
    case (r_state)
      StIdle: begin
        if (w_accept && !w_req_illegal) w_state_nxt = StOpc;
      end
      StOpc: begin
        word_data = w_opcode;
        word_idx  = 2'd0;
        word_last = !w_need_src && !w_need_dst;
        if (w_consume) begin
          if (w_need_src)      w_state_nxt = StExtSrc;
          else if (w_need_dst) w_state_nxt = StExtDst;
          else                 w_state_nxt = StIdle;
        end
      end
      StExtSrc: begin
        word_data = r_ext_src;
        word_idx  = 2'd1;
        word_last = !w_need_dst;
        if (w_consume) w_state_nxt = w_need_dst ? StExtDst : StIdle;
      end
      StExtDst: begin
        word_data = r_ext_dst;
        word_idx  = 2'd2;
        word_last = 1'b1;
        if (w_consume) w_state_nxt = StIdle;
      end
      default: w_state_nxt = StIdle;
    endcase
  end

  // State register.
  always_ff @(posedge mclk) begin
    if (!puc_rst_n) r_state <= StIdle;
    else            r_state <= w_state_nxt;
  end

  // Request field capture; fields stay frozen until the next acceptance.
  always_ff @(posedge mclk) begin
    if (!puc_rst_n) begin
      r_fmt     <= 2'd0;
      r_op      <= 4'd0;
      r_bw      <= 1'b0;
      r_src     <= 4'd0;
      r_as      <= 2'd0;
      r_dst     <= 4'd0;
      r_ad      <= 1'b0;
      r_joff    <= 10'd0;
      r_ext_src <= 16'h0000;
      r_ext_dst <= 16'h0000;
    end else if (w_accept) begin
      r_fmt     <= req_fmt;
      r_op      <= req_op;
      r_bw      <= req_bw;
      r_src     <= req_src;
      r_as      <= req_as;
      r_dst     <= req_dst;
      r_ad      <= req_ad;
      r_joff    <= req_joff;
      r_ext_src <= req_ext_src;
      r_ext_dst <= req_ext_dst;
    end
  end

  // Error pulse for the cycle after an illegal request is accepted.
  always_ff @(posedge mclk) begin
    if (!puc_rst_n) r_err <= 1'b0;
    else            r_err <= w_accept && w_req_illegal;
  end

  // Completed-instruction counter, wraps naturally at 32 bits.
  always_ff @(posedge mclk) begin
    if (!puc_rst_n)                  r_inst_count <= 32'd0;
    else if (w_consume && word_last) r_inst_count <= r_inst_count + 32'd1;
  end

endmodule

// File: tb/tb_msp430_inst_encoder.sv
// Directed self-checking bench for msp430_inst_encoder.
module tb_msp430_inst_encoder;

  logic        mclk = 1'b0;
  logic        puc_rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_fmt;
  logic [3:0]  req_op;
  logic        req_bw;
  logic [3:0]  req_src;
  logic [1:0]  req_as;
  logic [3:0]  req_dst;
  logic        req_ad;
  logic [9:0]  req_joff;
  logic [15:0] req_ext_src;
  logic [15:0] req_ext_dst;
  logic        word_valid;
  logic        word_ready;
  logic [15:0] word_data;
  logic        word_last;
  logic [1:0]  word_idx;
  logic        err;
  logic        busy;
  logic [31:0] inst_count;

  int n_cmp = 0;
  int n_bad = 0;
  int exp_cnt = 0;

  msp430_inst_encoder u_dut (
    .mclk        (mclk),
    .puc_rst_n   (puc_rst_n),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_fmt     (req_fmt),
    .req_op      (req_op),
    .req_bw      (req_bw),
    .req_src     (req_src),
    .req_as      (req_as),
    .req_dst     (req_dst),
    .req_ad      (req_ad),
    .req_joff    (req_joff),
    .req_ext_src (req_ext_src),
    .req_ext_dst (req_ext_dst),
    .word_valid  (word_valid),
    .word_ready  (word_ready),
    .word_data   (word_data),
    .word_last   (word_last),
    .word_idx    (word_idx),
    .err         (err),
    .busy        (busy),
    .inst_count  (inst_count)
  );

  always #5 mclk = ~mclk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic set_req(input logic [1:0] fmt, input logic [3:0] op, input logic bw,
                         input logic [3:0] src, input logic [1:0] as_, input logic [3:0] dst,
                         input logic ad, input logic [9:0] joff, input logic [15:0] xs,
                         input logic [15:0] xd);
    req_fmt     = fmt;
    req_op      = op;
    req_bw      = bw;
    req_src     = src;
    req_as      = as_;
    req_dst     = dst;
    req_ad      = ad;
    req_joff    = joff;
    req_ext_src = xs;
    req_ext_dst = xd;
  endtask

  // Presents a request for one edge, then scrambles the fields to prove they were latched.
  task automatic issue(input logic [1:0] fmt, input logic [3:0] op, input logic bw,
                       input logic [3:0] src, input logic [1:0] as_, input logic [3:0] dst,
                       input logic ad, input logic [9:0] joff, input logic [15:0] xs,
                       input logic [15:0] xd);
    set_req(fmt, op, bw, src, as_, dst, ad, joff, xs, xd);
    req_valid = 1'b1;
    @(negedge mclk);
    req_valid = 1'b0;
    set_req(2'd3, 4'hF, 1'b1, 4'hF, 2'd3, 4'hF, 1'b1, 10'h155, 16'hDEAD, 16'hBEEF);
  endtask

  task automatic expect_word(input string tag, input logic [15:0] data, input logic [1:0] idx,
                             input logic last);
    check({tag, ".valid"}, 32'(word_valid), 32'd1);
    check({tag, ".data"},  32'(word_data),  32'(data));
    check({tag, ".idx"},   32'(word_idx),   32'(idx));
    check({tag, ".last"},  32'(word_last),  32'(last));
    @(negedge mclk);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    puc_rst_n  = 1'b0;
    word_ready = 1'b1;
    req_valid  = 1'b1;
    set_req(2'd2, 4'd4, 1'b0, 4'd5, 2'd0, 4'd6, 1'b0, 10'd0, 16'd0, 16'd0);
    repeat (3) @(negedge mclk);

    // Reset state, with a request pending that must not be accepted
    check("rst.req_ready",  32'(req_ready),  32'd0);
    check("rst.word_valid", 32'(word_valid), 32'd0);
    check("rst.word_data",  32'(word_data),  32'd0);
    check("rst.word_last",  32'(word_last),  32'd0);
    check("rst.word_idx",   32'(word_idx),   32'd0);
    check("rst.err",        32'(err),        32'd0);
    check("rst.busy",       32'(busy),       32'd0);
    check("rst.count",      inst_count,      32'd0);
    req_valid = 1'b0;
    puc_rst_n = 1'b1;
    @(negedge mclk);
    check("idle.req_ready", 32'(req_ready), 32'd1);
    check("idle.busy",      32'(busy),      32'd0);

    // MOV.W R5,R6
    issue(2'd2, 4'd4, 1'b0, 4'd5, 2'd0, 4'd6, 1'b0, 10'd0, 16'd0, 16'd0);
    check("mov.busy",      32'(busy),      32'd1);
    check("mov.req_ready", 32'(req_ready), 32'd0);
    expect_word("mov", 16'h4506, 2'd0, 1'b1);
    exp_cnt++;
    check("mov.done_valid", 32'(word_valid), 32'd0);
    check("mov.count",      inst_count,      32'(exp_cnt));

    // ADD #0x1234,&0x0200 with 3 cycles of backpressure on the opcode word
    word_ready = 1'b0;
    issue(2'd2, 4'd5, 1'b0, 4'd0, 2'd3, 4'd2, 1'b1, 10'd0, 16'h1234, 16'h0200);
    for (int i = 0; i < 3; i++) begin
      check("bp.valid", 32'(word_valid), 32'd1);
      check("bp.data",  32'(word_data),  32'h50B2);
      @(negedge mclk);
    end
    word_ready = 1'b1;
    expect_word("add.op",  16'h50B2, 2'd0, 1'b0);
    expect_word("add.src", 16'h1234, 2'd1, 1'b0);
    expect_word("add.dst", 16'h0200, 2'd2, 1'b1);
    exp_cnt++;
    check("add.done_valid", 32'(word_valid), 32'd0);
    check("add.count",      inst_count,      32'(exp_cnt));

    // JMP -1
    issue(2'd1, 4'd7, 1'b0, 4'd0, 2'd0, 4'd0, 1'b0, 10'h3FF, 16'd0, 16'd0);
    expect_word("jmp", 16'h3FFF, 2'd0, 1'b1);
    exp_cnt++;

    // CALL #0xF000 with bw=1 that must be forced to 0
    issue(2'd0, 4'd5, 1'b1, 4'd0, 2'd3, 4'd0, 1'b0, 10'd0, 16'hF000, 16'd0);
    expect_word("call.op",  16'h12B0, 2'd0, 1'b0);
    expect_word("call.src", 16'hF000, 2'd1, 1'b1);
    exp_cnt++;

    // RETI with noisy operand fields: fixed word, no extension
    issue(2'd0, 4'd6, 1'b1, 4'd0, 2'd3, 4'd0, 1'b0, 10'd0, 16'h5555, 16'd0);
    expect_word("reti", 16'h1300, 2'd0, 1'b1);
    exp_cnt++;

    // MOV.B #1 via constant generator (as=01, src=3): no source extension
    issue(2'd2, 4'd4, 1'b1, 4'd3, 2'd1, 4'd5, 1'b0, 10'd0, 16'h7777, 16'd0);
    expect_word("cg", 16'h4355, 2'd0, 1'b1);
    exp_cnt++;

    // MOV.W 0x10(R4),R5 (as=01, src=4): source extension required
    issue(2'd2, 4'd4, 1'b0, 4'd4, 2'd1, 4'd5, 1'b0, 10'd0, 16'h0010, 16'd0);
    expect_word("idx.op",  16'h4415, 2'd0, 1'b0);
    expect_word("idx.src", 16'h0010, 2'd1, 1'b1);
    exp_cnt++;
    check("seq.count", inst_count, 32'(exp_cnt));

    // Illegal requests: fmt=3, TWO-OP op<4, SIG-OP op>6
    issue(2'd3, 4'd4, 1'b0, 4'd5, 2'd0, 4'd6, 1'b0, 10'd0, 16'd0, 16'd0);
    check("ill3.err",       32'(err),        32'd1);
    check("ill3.valid",     32'(word_valid), 32'd0);
    check("ill3.req_ready", 32'(req_ready),  32'd1);
    @(negedge mclk);
    check("ill3.err_off", 32'(err),        32'd0);
    check("ill3.valid2",  32'(word_valid), 32'd0);
    check("ill3.count",   inst_count,      32'(exp_cnt));
    issue(2'd2, 4'd3, 1'b0, 4'd5, 2'd0, 4'd6, 1'b0, 10'd0, 16'd0, 16'd0);
    check("ill2.err",   32'(err),        32'd1);
    check("ill2.valid", 32'(word_valid), 32'd0);
    issue(2'd0, 4'd7, 1'b0, 4'd5, 2'd0, 4'd6, 1'b0, 10'd0, 16'd0, 16'd0);
    check("ill0.err",   32'(err),        32'd1);
    check("ill0.valid", 32'(word_valid), 32'd0);
    @(negedge mclk);
    check("ill.count", inst_count, 32'(exp_cnt));

    // A request held while busy waits until the FSM returns to IDLE
    word_ready = 1'b0;
    issue(2'd2, 4'd4, 1'b0, 4'd5, 2'd0, 4'd6, 1'b0, 10'd0, 16'd0, 16'd0);
    set_req(2'd1, 4'd7, 1'b0, 4'd0, 2'd0, 4'd0, 1'b0, 10'h3FF, 16'd0, 16'd0);
    req_valid = 1'b1;
    check("hold.req_ready", 32'(req_ready), 32'd0);
    @(negedge mclk);
    check("hold.data", 32'(word_data), 32'h4506);
    word_ready = 1'b1;
    @(negedge mclk);
    exp_cnt++;
    check("hold.gap_valid", 32'(word_valid), 32'd0);
    check("hold.req_ready2", 32'(req_ready), 32'd1);
    @(negedge mclk);
    req_valid = 1'b0;
    expect_word("hold.jmp", 16'h3FFF, 2'd0, 1'b1);
    exp_cnt++;
    check("hold.count", inst_count, 32'(exp_cnt));

    // Reset after the ADD opcode word aborts the instruction
    issue(2'd2, 4'd5, 1'b0, 4'd0, 2'd3, 4'd2, 1'b1, 10'd0, 16'h1234, 16'h0200);
    expect_word("abort.op", 16'h50B2, 2'd0, 1'b0);
    puc_rst_n = 1'b0;
    @(negedge mclk);
    check("abort.rst_ready", 32'(req_ready), 32'd0);
    puc_rst_n = 1'b1;
    check("abort.valid", 32'(word_valid), 32'd0);
    check("abort.data",  32'(word_data),  32'd0);
    @(negedge mclk);
    exp_cnt = 0;
    check("abort.valid2", 32'(word_valid), 32'd0);
    check("abort.count",  inst_count,      32'(exp_cnt));
    issue(2'd2, 4'd4, 1'b0, 4'd5, 2'd0, 4'd6, 1'b0, 10'd0, 16'd0, 16'd0);
    expect_word("post", 16'h4506, 2'd0, 1'b1);
    exp_cnt++;
    check("post.count", inst_count, 32'(exp_cnt));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
